decimal_bcd_encoder: RTL and testbench

- Decimal-to-BCD keypad encoder: takes ten active-low decimal lines `key_n[9:0]` and produces the 4-bit BCD code of the pressed key.
- Key lines use the same active-low, one-line-per-digit convention the BCD-to-decimal decoder drives: `key_n[k]` low means digit k.
- Synchronises and debounces the lines, rejects multi-key presses, and emits one valid pulse per press.
- Shifts accepted digits into an N-digit BCD entry register that feeds the display/decoder path.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/decimal_bcd_encoder_key_sync.sv | 23 ++
 rtl/decimal_bcd_encoder.sv | 118 +++++++++++
 tb/tb_decimal_bcd_encoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the decimal keypad to BCD encoder.
package bcd_pkg;

  localparam int          BCD_W    = 4;
  localparam int          KEY_W    = 10;
  localparam logic [9:0]  KEY_NONE = 10'h3FF;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  typedef enum logic [1:0] {PAT_NONE, PAT_ONE, PAT_MULTI} pat_t;

  // Index of the lowest low bit; only meaningful for a single-low pattern.
  function automatic logic [BCD_W-1:0] key_index(input logic [KEY_W-1:0] k);
    logic [BCD_W-1:0] idx;
    idx = '0;
    for (int i = KEY_W-1; i >= 0; i--)
      if (!k[i]) idx = BCD_W'(i);
    return idx;
  endfunction

  function automatic pat_t key_class(input logic [KEY_W-1:0] k);
    int lows;
    lows = 0;
    for (int i = 0; i < KEY_W; i++)
      if (!k[i]) lows++;
    if (lows == 0)      return PAT_NONE;
    else if (lows == 1) return PAT_ONE;
    else                return PAT_MULTI;
  endfunction

endpackage

// File: rtl/decimal_bcd_encoder_key_sync.sv
// Two-flop synchroniser for active-low key lines; resets to "nothing pressed".
module key_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/decimal_bcd_encoder.sv
// Keypad encoder: sync, debounce, single-key accept with no auto-repeat,
// and a shifting BCD entry register.
module decimal_bcd_encoder
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [KEY_W-1:0]                  key_n,
  input  logic                              clear,
  output logic [BCD_W-1:0]                  bcd_out,
  output logic                              valid,
  output logic                              multi,
  output logic [BCD_W*NUM_DIGITS-1:0]       digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES+1);
  localparam int CW    = $clog2(NUM_DIGITS+1);
  localparam int DW    = BCD_W*NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES-1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(NUM_DIGITS);

  logic [KEY_W-1:0] ks, cand;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  pat_t             pat;
  logic             accept;
  logic [BCD_W-1:0] code;

  key_sync #(.W(KEY_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (ks)
  );

  // A one-cycle debounce accepts straight out of IDLE.
  always_comb begin
    pat    = key_class(ks);
    accept = 1'b0;
    code   = key_index(ks);
    if (state == IDLE && pat == PAT_ONE && DEBOUNCE_CYCLES == 1)
      accept = 1'b1;
    if (state == DEBOUNCE && ks == cand && cnt == CNT_LAST)
      accept = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cand    <= KEY_NONE;
      bcd_out <= '0;
      valid   <= 1'b0;
      multi   <= 1'b0;
    end else begin
      valid <= 1'b0;
      multi <= 1'b0;
      if (accept) begin
        valid   <= 1'b1;
        bcd_out <= code;
      end
      case (state)
        IDLE: begin
          multi <= (pat == PAT_MULTI);
          if (pat == PAT_ONE) begin
            cand  <= ks;
            cnt   <= CNT_W'(1);
            state <= accept ? PRESSED : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (ks != cand) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (accept) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (pat == PAT_NONE) begin
            cnt   <= CNT_W'(1);
            state <= (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (pat != PAT_NONE) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear beats a coincident accept for the entry register only.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digits      <= '0;
      digit_count <= '0;
    end else if (accept) begin
      digits <= (digits << BCD_W) | DW'(code);
      if (digit_count != CNT_FULL)
        digit_count <= digit_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_decimal_bcd_encoder.sv
// Directed bench for decimal_bcd_encoder at default parameters.
module tb_decimal_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  key_n;
  logic        clear;
  logic [3:0]  bcd_out;
  logic        valid;
  logic        multi;
  logic [15:0] digits;
  logic [2:0]  digit_count;

  int errors = 0;
  int checks = 0;

  decimal_bcd_encoder #(.DEBOUNCE_CYCLES(4), .NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .clear       (clear),
    .bcd_out     (bcd_out),
    .valid       (valid),
    .multi       (multi),
    .digits      (digits),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] kn(input int k);
    logic [9:0] one;
    one = 10'd1;
    return ~(one << k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles; report valid pulses and the cycle (1-based) of the first.
  task automatic run(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; key_n = kn(5);
    tick(); tick(); tick();
    checks++; if (bcd_out !== 4'd0) begin errors++; $display("FAIL reset_bcd got=%0d exp=0", bcd_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (multi !== 1'b0) begin errors++; $display("FAIL reset_multi got=%b exp=0", multi); end
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
    key_n = 10'h3FF;
    rst = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_single_press();
    int p, f;
    key_n = 10'h37F;
    run(20, p, f);
    checks++; if (p !== 1) begin errors++; $display("FAIL press7_pulses got=%0d exp=1", p); end
    checks++; if (f !== 6) begin errors++; $display("FAIL press7_latency got=%0d exp=6", f); end
    checks++; if (bcd_out !== 4'd7) begin errors++; $display("FAIL press7_bcd got=%0d exp=7", bcd_out); end
    checks++; if (digits !== 16'h0007) begin errors++; $display("FAIL press7_digits got=%h exp=0007", digits); end
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL press7_count got=%0d exp=1", digit_count); end
    key_n = 10'h3FF;
    run(10, p, f);
    checks++; if (p !== 0) begin errors++; $display("FAIL press7_release_pulses got=%0d exp=0", p); end
  endtask

  task automatic test_bounce();
    int p, f, tot;
    tot = 0;
    for (int j = 0; j < 6; j++) begin
      key_n = (j % 2 == 0) ? kn(3) : 10'h3FF;
      run(2, p, f);
      tot += p;
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL bounce_pulses got=%0d exp=0", tot); end
    key_n = kn(3);
    run(12, p, f);
    checks++; if (p !== 1) begin errors++; $display("FAIL bounce_stable_pulses got=%0d exp=1", p); end
    checks++; if (f !== 6) begin errors++; $display("FAIL bounce_latency got=%0d exp=6", f); end
    checks++; if (bcd_out !== 4'd3) begin errors++; $display("FAIL bounce_bcd got=%0d exp=3", bcd_out); end
    checks++; if (digits !== 16'h0073) begin errors++; $display("FAIL bounce_digits got=%h exp=0073", digits); end
    key_n = 10'h3FF;
    run(10, p, f);
  endtask

  task automatic test_multi();
    int p, f;
    key_n = 10'h3DB;
    run(8, p, f);
    checks++; if (p !== 0) begin errors++; $display("FAIL multi_pulses got=%0d exp=0", p); end
    checks++; if (multi !== 1'b1) begin errors++; $display("FAIL multi_level got=%b exp=1", multi); end
    key_n = kn(2);
    run(10, p, f);
    checks++; if (p !== 1) begin errors++; $display("FAIL multi_single_pulses got=%0d exp=1", p); end
    checks++; if (f !== 6) begin errors++; $display("FAIL multi_single_latency got=%0d exp=6", f); end
    checks++; if (bcd_out !== 4'd2) begin errors++; $display("FAIL multi_single_bcd got=%0d exp=2", bcd_out); end
    checks++; if (multi !== 1'b0) begin errors++; $display("FAIL multi_cleared got=%b exp=0", multi); end
    key_n = 10'h3FF;
    run(10, p, f);
  endtask

  task automatic test_entry_saturate();
    int p, f, tot;
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", digit_count); end
    tot = 0;
    for (int k = 1; k <= 5; k++) begin
      key_n = kn(k);
      run(10, p, f);
      tot += p;
      key_n = 10'h3FF;
      run(10, p, f);
      tot += p;
      if (k == 4) begin
        checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL entry4_digits got=%h exp=1234", digits); end
      end
    end
    checks++; if (tot !== 5) begin errors++; $display("FAIL entry_pulses got=%0d exp=5", tot); end
    checks++; if (digits !== 16'h2345) begin errors++; $display("FAIL entry5_digits got=%h exp=2345", digits); end
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL entry_count got=%0d exp=4", digit_count); end
  endtask

  task automatic test_clear_on_accept();
    int p, f;
    key_n = kn(9);
    run(5, p, f);
    checks++; if (p !== 0) begin errors++; $display("FAIL clr9_early_pulses got=%0d exp=0", p); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL clr9_valid got=%b exp=1", valid); end
    checks++; if (bcd_out !== 4'd9) begin errors++; $display("FAIL clr9_bcd got=%0d exp=9", bcd_out); end
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL clr9_digits got=%h exp=0000", digits); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL clr9_count got=%0d exp=0", digit_count); end
    run(10, p, f);
    checks++; if (p !== 0) begin errors++; $display("FAIL clr9_held_repeat got=%0d exp=0", p); end
    key_n = 10'h3FF;
    run(10, p, f);
  endtask

  task automatic test_reset_pressed();
    int p, f;
    key_n = kn(8);
    run(10, p, f);
    checks++; if (p !== 1) begin errors++; $display("FAIL rst8_first_pulses got=%0d exp=1", p); end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bcd_out !== 4'd0) begin errors++; $display("FAIL rst8_bcd got=%0d exp=0", bcd_out); end
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL rst8_digits got=%h exp=0000", digits); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL rst8_count got=%0d exp=0", digit_count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst8_valid got=%b exp=0", valid); end
    run(3, p, f);
    key_n = 10'h3FF;
    run(10, p, f);
    checks++; if (p !== 0) begin errors++; $display("FAIL rst8_no_pulse got=%0d exp=0", p); end
    key_n = kn(8);
    run(10, p, f);
    checks++; if (p !== 1) begin errors++; $display("FAIL rst8_repress_pulses got=%0d exp=1", p); end
    checks++; if (f !== 6) begin errors++; $display("FAIL rst8_repress_latency got=%0d exp=6", f); end
    checks++; if (bcd_out !== 4'd8) begin errors++; $display("FAIL rst8_repress_bcd got=%0d exp=8", bcd_out); end
    checks++; if (digits !== 16'h0008) begin errors++; $display("FAIL rst8_repress_digits got=%h exp=0008", digits); end
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL rst8_repress_count got=%0d exp=1", digit_count); end
    key_n = 10'h3FF;
    run(10, p, f);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_entry_saturate();
    test_clear_on_accept();
    test_reset_pressed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
